// File: rtl/note_gen_if.sv
`default_nettype none
// note_gen_if: control strobe, tone/volume settings and sample outputs of note_gen.
// Revision 1.0
interface note_gen_if #(
  parameter int DIV_W = 22
);
  logic                    load;
  logic [DIV_W-1:0]        div_left;
  logic [DIV_W-1:0]        div_right;
  logic [3:0]              volume;
  logic                    mute;
  logic signed [15:0]      audio_left;
  logic signed [15:0]      audio_right;
  logic                    settled;

  modport master (
    output load, div_left, div_right, volume, mute,
    input  audio_left, audio_right, settled
  );

  modport slave (
    input  load, div_left, div_right, volume, mute,
    output audio_left, audio_right, settled
  );
endinterface
`default_nettype wire

// File: rtl/note_gen.sv
`default_nettype none
// note_gen: two-channel square-wave tone generator with a shared click-free amplitude ramp.
// Revision 1.0
module note_gen #(
  parameter int DIV_W       = 22,
  parameter int RAMP_CYCLES = 4096,
  parameter int RAMP_STEP   = 256
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  note_gen_if.slave   bus
);

  localparam int                 c_PRE_W    = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(RAMP_CYCLES - 1);
  localparam logic [14:0]        c_STEP     = 15'(RAMP_STEP);

  logic [3:0]         r_vol;
  logic [14:0]        r_amp_cur;
  logic [c_PRE_W-1:0] r_pre;

  logic [14:0]        w_amp_tgt;
  logic [14:0]        w_diff;
  logic [14:0]        w_delta;
  logic [14:0]        w_amp_nxt;
  logic               w_up;
  logic               w_pre_tc;

  // Step toward the target by at most c_STEP so the ramp can never overshoot.
  always_comb begin
    w_amp_tgt = bus.mute ? 15'd0 : {r_vol, 11'd0};
    w_up      = (w_amp_tgt > r_amp_cur);
    w_diff    = w_up ? (w_amp_tgt - r_amp_cur) : (r_amp_cur - w_amp_tgt);
    w_delta   = (w_diff > c_STEP) ? c_STEP : w_diff;
    w_amp_nxt = w_up ? (r_amp_cur + w_delta) : (r_amp_cur - w_delta);
  end

  assign w_pre_tc    = (r_pre == c_PRE_LAST);
  assign bus.settled = (r_amp_cur == w_amp_tgt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vol <= 4'd0;
    end else if (bus.load) begin
      r_vol <= bus.volume;
    end
  end

  // Free-running; deliberately untouched by load and mute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_pre_tc) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + c_PRE_W'(1);
    end
  end

  // A load coinciding with a terminal count steps toward the old target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_amp_cur <= 15'd0;
    end else if (w_pre_tc) begin
      r_amp_cur <= w_amp_nxt;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [DIV_W-1:0] w_div_in;
    logic [15:0]      w_mag;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_ph;
    logic [15:0]      r_audio;

    assign w_div_in = (g == 0) ? bus.div_left : bus.div_right;
    assign w_mag    = {1'b0, r_amp_cur};

    // Load wins over a coincident wrap so the new tone always starts in phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_div <= '0;
        r_cnt <= '0;
        r_ph  <= 1'b0;
      end else if (bus.load) begin
        r_div <= w_div_in;
        r_cnt <= '0;
        r_ph  <= 1'b0;
      end else if (r_div == '0) begin
        r_cnt <= '0;
        r_ph  <= 1'b0;
      end else if (r_cnt == (r_div - DIV_W'(1))) begin
        r_cnt <= '0;
        r_ph  <= ~r_ph;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end

    // A silent channel keeps phase 0 but must output zero, not -amp_cur.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_audio <= 16'd0;
      end else if (r_div == '0) begin
        r_audio <= 16'd0;
      end else if (r_ph) begin
        r_audio <= w_mag;
      end else begin
        r_audio <= 16'd0 - w_mag;
      end
    end
  end

  assign bus.audio_left  = g_ch[0].r_audio;
  assign bus.audio_right = g_ch[1].r_audio;

endmodule
`default_nettype wire

// File: tb/tb_note_gen.sv
`default_nettype none
// tb_note_gen: scoreboard bench for note_gen; expected samples are queued per cycle and checked by a monitor.
// Revision 1.0
module tb_note_gen;

  localparam int DIV_W       = 22;
  localparam int RAMP_CYCLES = 4;
  localparam int RAMP_STEP   = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    int          cyc;
    logic [15:0] l;
    logic [15:0] r;
    logic        s;
    bit          cl;
    bit          cr;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  note_gen_if #(.DIV_W(DIV_W)) bus ();

  note_gen #(
    .DIV_W      (DIV_W),
    .RAMP_CYCLES(RAMP_CYCLES),
    .RAMP_STEP  (RAMP_STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every queued expectation on the cycle it falls due.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc ||
            (e.cl && bus.audio_left  !== e.l) ||
            (e.cr && bus.audio_right !== e.r) ||
            bus.settled !== e.s) begin
          failures++;
          $display("FAIL %s cyc=%0d due=%0d: actual L=%h R=%h settled=%b, required L=%h(%0d) R=%h(%0d) settled=%b",
                   e.name, cyc, e.cyc, bus.audio_left, bus.audio_right, bus.settled,
                   e.l, e.cl, e.r, e.cr, e.s);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int mag(logic [15:0] v);
    int x;
    x = $signed(v);
    return (x < 0) ? -x : x;
  endfunction

  // Sample expected t edges after the load edge; the phase flips every div cycles.
  function automatic logic [15:0] exp_val(int t, int div, int amp);
    if (div == 0 || amp == 0) return 16'h0000;
    return (((t / div) % 2) == 1) ? 16'(amp) : 16'(-amp);
  endfunction

  // Entry n is due at cyc base+n; audio then reflects the state n-2 edges after the load edge.
  task automatic push_tone(input int base, input int n0, input int n1, input int amp,
                           input int dl, input int dr, input string nm);
    exp_t x;
    for (int n = n0; n <= n1; n++) begin
      x.cyc  = base + n;
      x.l    = exp_val(n - 2, dl, amp);
      x.r    = exp_val(n - 2, dr, amp);
      x.s    = 1'b1;
      x.cl   = 1'b1;
      x.cr   = 1'b1;
      x.name = nm;
      sb.push_back(x);
    end
  endtask

  task automatic push_unsettled(input int due, input string nm);
    exp_t x;
    x.cyc  = due;
    x.l    = 16'h0;
    x.r    = 16'h0;
    x.s    = 1'b0;
    x.cl   = 1'b0;
    x.cr   = 1'b0;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Drives a one-cycle load; base is the cycle count when it was driven (load edge -> base+1).
  task automatic load_cfg(input int dl, input int dr, input int v, input bit unsettled,
                          output int base);
    @(negedge clk);
    bus.load      = 1'b1;
    bus.div_left  = DIV_W'(dl);
    bus.div_right = DIV_W'(dr);
    bus.volume    = 4'(v);
    base          = cyc;
    if (unsettled) push_unsettled(base + 1, "unsettled_after_load");
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Waits for settled, checking that every visible amplitude change is exactly one step.
  task automatic wait_settled(input int bound, input string nm, output int done_cyc);
    int prev;
    int cur;
    int k;
    prev = mag(bus.audio_left);
    k    = 0;
    do begin
      @(negedge clk);
      k++;
      cur = mag(bus.audio_left);
      if (cur != prev) begin
        checks++;
        if (cur - prev != RAMP_STEP && prev - cur != RAMP_STEP) begin
          failures++;
          $display("FAIL %s_step cyc=%0d: actual delta=%0d required=+/-%0d", nm, cyc, cur - prev, RAMP_STEP);
        end
        prev = cur;
      end
    end while (bus.settled !== 1'b1 && k < bound);
    done_cyc = cyc;
    chk({nm, "_settle_timeout"}, int'(bus.settled === 1'b1), 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: actual pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int b;
    int b2;
    int done;
    int k;

    bus.load      = 1'b0;
    bus.div_left  = '0;
    bus.div_right = '0;
    bus.volume    = 4'd0;
    bus.mute      = 1'b0;

    // Reset state.
    push_tone(0, 1, 3, 0, 0, 0, "reset_state");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    drain();

    // Full-scale ramp, then steady tones on both channels.
    load_cfg(4, 6, 15, 1'b1, b);
    wait_settled(600, "ramp_up", done);
    chk_range("ramp_up_time", done - b, 478, 481);
    push_tone(b, done - b + 1, done - b + 24, 30720, 4, 6, "full_scale_tone");
    drain();

    // Mute ramps down to silence.
    @(negedge clk);
    bus.mute = 1'b1;
    b2 = cyc;
    push_unsettled(b2 + 1, "unsettled_after_mute");
    wait_settled(600, "mute_down", done);
    chk_range("mute_down_time", done - b2, 477, 480);
    push_tone(done, 2, 9, 0, 4, 6, "muted_silence");
    drain();

    // Unmute and retarget mid-ramp at 12800.
    @(negedge clk);
    bus.mute = 1'b0;
    k = 0;
    while (mag(bus.audio_left) != 12800 && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("unmute_reaches_12800", mag(bus.audio_left), 12800);
    load_cfg(4, 6, 3, 1'b1, b);
    wait_settled(300, "retarget_down", done);
    push_tone(b, done - b + 1, done - b + 16, 6144, 4, 6, "retarget_6144");
    drain();

    // Silent left channel, right divides by 5.
    load_cfg(0, 5, 3, 1'b0, b);
    push_tone(b, 2, 21, 6144, 0, 5, "div0_left_silent");
    drain();

    // Left divides by 1: toggles every cycle.
    load_cfg(1, 5, 3, 1'b0, b);
    push_tone(b, 2, 13, 6144, 1, 5, "div1_left");
    drain();

    // Reload on the exact wrap edge of a div=4 channel.
    load_cfg(4, 5, 3, 1'b0, b);
    repeat (2) @(negedge clk);
    load_cfg(4, 5, 3, 1'b0, b2);
    chk("wrap_load_alignment", b2 - b, 4);
    push_tone(b2, 2, 17, 6144, 4, 5, "load_on_wrap");
    drain();

    // Asynchronous reset mid-tone at full amplitude.
    load_cfg(4, 6, 15, 1'b1, b);
    wait_settled(600, "ramp_up2", done);
    push_tone(b, done - b + 1, done - b + 8, 30720, 4, 6, "full_scale_tone2");
    drain();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_left",    int'(bus.audio_left),  0);
    chk("async_reset_right",   int'(bus.audio_right), 0);
    chk("async_reset_settled", int'(bus.settled),     1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_tone(cyc, 1, 10, 0, 4, 6, "post_reset_silence");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_gen.md
# note_gen

Two-channel square-wave tone generator that produces the 16-bit signed left/right samples consumed by the audio serializer. Each channel divides the 40 MHz system clock by a programmable half-period to form a tone. A shared, click-free amplitude ramp moves toward a volume target. Outputs are registered and held stable between updates, so the serializer can sample them at any time.

## Interface
- DIV_W, 22: width of the half-period dividers; the lowest tone is clk/(2·(2^DIV_W−1)).
- RAMP_CYCLES, 4096: clk cycles between amplitude ramp steps.
- RAMP_STEP, 256: maximum amplitude change per ramp step.
- clk  in  1  system clock (40 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  single-cycle strobe; latches div_left, div_right and volume.
- div_left  in  DIV_W  left half-period in clk cycles; 0 = silent.
- div_right  in  DIV_W  right half-period in clk cycles; 0 = silent.
- volume  in  4  target level 0..15; amplitude = volume·2048.
- mute  in  1  live level; forces the target amplitude to 0 while high.
- audio_left  out  16  signed left sample.
- audio_right  out  16  signed right sample.
- settled  out  1  high when the current amplitude equals the target.

## Operation
- Latched registers: div_l, div_r, vol. All are written only on a clk edge where load=1.
- On that same edge, both phase counters clear to 0 and both phase bits clear to 0.
- Per channel with div≠0:
  - The counter increments each cycle.
  - When counter==div−1, the counter wraps to 0 and the phase bit toggles.
  - Each phase therefore lasts exactly div cycles; the tone period is 2·div.
- Per channel with div==0: the counter and phase are held at 0, and that channel outputs 0.
- amp_tgt = mute ? 0 : vol·2048 (unsigned 15-bit; maximum 30720 = 0x7800).
- Ramp prescaler:
  - Free-running, counting 0..RAMP_CYCLES−1.
  - On its terminal count, amp_cur moves toward amp_tgt by min(RAMP_STEP, |amp_tgt−amp_cur|).
  - amp_cur therefore never overshoots.
  - The prescaler is not cleared by load or mute.
- Sample formation:
  - phase=1 → +amp_cur; phase=0 → −amp_cur (two's complement, 16-bit).
  - amp_cur=0 yields 0x0000 in both phases.
- settled is combinational from the registers: (amp_cur==amp_tgt).
- Retargeting is allowed at any time:
  - A load or mute change in mid-ramp retargets immediately.
  - The ramp continues from the present amp_cur; there is no jump.
- Simultaneous events:
  - load on the wrap cycle: the load takes priority, so the counter goes to 0 and phase goes to 0.
  - load on a ramp terminal count: that step is taken toward the old target; the new target applies from the next step.

## Timing
- Reset values:
  - audio_left=0, audio_right=0, settled=1.
  - amp_cur=0, vol=0, div_l=div_r=0, all counters 0, phases 0.
- Reset is asynchronous at assertion and takes effect mid-operation with no residual state.
- Output latency: audio_x registers phase/amp_cur one cycle after they change.
  - Example: a phase toggle at edge N is visible on audio_x after edge N+1.
- load→first output effect: the latched registers update at edge L; audio_x reflects phase 0 after edge L+1.
- Ramp step: amp_cur changes at the prescaler terminal edge; audio_x reflects it one edge later.
- Full-scale ramp time: 0→30720 takes 120 steps = 120·RAMP_CYCLES cycles (12.3 ms at defaults).
- audio_x changes at most once per clk cycle and is never glitchy, because it is registered.

## Test plan
- Reset, then load div_left=4, div_right=6, volume=15 with RAMP_CYCLES=4 → settled drops after the load, and amp_cur reaches 30720 after 120 steps (480 cycles). Once settled:
  - audio_left alternates 0x8800/0x7800 every 4 cycles.
  - audio_right alternates every 6 cycles.
- From the settled state, raise mute → amplitude falls by 256 per 4 cycles to 0. Then:
  - Both outputs are 0x0000 and settled=1.
  - Deasserting mute ramps back up to 30720.
- Mid-ramp reload: at amp_cur=12800, load volume=3 (target 6144) → amp_cur steps down by 256 to 6144 with no overshoot, then settled=1.
- Load with div_left=0, div_right=5 → audio_left is held at 0x0000 while audio_right toggles every 5 cycles. Then load div_left=1 → audio_left toggles every cycle.
- Load asserted on the exact wrap cycle with div_left=4 → phase=0 and counter=0 on the next cycle. The next toggle occurs 4 cycles later.
- Assert rst_n low mid-tone at full amplitude → all outputs are 0 and settled=1 immediately. After release, outputs stay 0 until a new load.
